// File: rtl/clock_disp_pkg.sv
// ============================================================================
// clock_disp_pkg : shared types and constants for the time display driver
// Rev 1.0
// ============================================================================
`default_nettype none

package clock_disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    localparam int c_HR_MSB  = 26;
    localparam int c_HR_LSB  = 22;
    localparam int c_MIN_MSB = 21;
    localparam int c_MIN_LSB = 16;
    localparam int c_SEC_MSB = 15;
    localparam int c_SEC_LSB = 10;
    localparam int c_MS_MSB  = 9;
    localparam int c_MS_LSB  = 0;

    function automatic logic [6:0] seg_decode(input logic [3:0] i_digit);
        logic [6:0] w_seg;
        case (i_digit)
            4'd0:    w_seg = c_SEG_0;
            4'd1:    w_seg = c_SEG_1;
            4'd2:    w_seg = c_SEG_2;
            4'd3:    w_seg = c_SEG_3;
            4'd4:    w_seg = c_SEG_4;
            4'd5:    w_seg = c_SEG_5;
            4'd6:    w_seg = c_SEG_6;
            4'd7:    w_seg = c_SEG_7;
            4'd8:    w_seg = c_SEG_8;
            4'd9:    w_seg = c_SEG_9;
            default: w_seg = c_SEG_BLANK;
        endcase
        return w_seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq : 6-bit binary to tens/units by repeated subtract-10
// Rev 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [5:0] i_bin,
    output logic       o_done,
    output logic [2:0] o_tens,
    output logic [3:0] o_units
);

    logic [5:0] r_rem;
    logic [2:0] r_tens;
    logic       r_busy;
    logic       r_fin;

    logic       w_sub;
    logic       w_last;
    logic [5:0] w_rem_nx;
    logic [2:0] w_tens_nx;

    assign w_sub     = r_busy && (r_rem >= 6'd10);
    assign w_last    = r_busy && (r_rem < 6'd20);
    assign w_rem_nx  = w_sub ? (r_rem - 6'd10) : r_rem;
    assign w_tens_nx = w_sub ? (r_tens + 3'd1) : r_tens;

    // Results are presented from the next-state view so done and the final
    // digits are valid in the same cycle as the last subtraction.
    assign o_done  = r_fin | w_last;
    assign o_tens  = w_tens_nx;
    assign o_units = 4'(w_rem_nx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= 6'd0;
            r_tens <= 3'd0;
            r_busy <= 1'b0;
            r_fin  <= 1'b0;
        end else if (i_start) begin
            r_rem  <= i_bin;
            r_tens <= 3'd0;
            r_busy <= 1'b1;
            r_fin  <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_rem_nx;
            r_tens <= w_tens_nx;
            if (w_last) begin
                r_busy <= 1'b0;
                r_fin  <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/time_disp_driver.sv
// ============================================================================
// time_disp_driver : 4-digit multiplexed 7-segment driver for HH:MM / MM:SS
// Optional macro BLINK_COLON_EN enables a 1 Hz colon on digit 2.
// Rev 1.0
// ============================================================================
`default_nettype none

module time_disp_driver
    import clock_disp_pkg::*;
#(
    parameter int DIGIT_CYC = 4
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic [26:0] disp_time,
    input  logic        show_sec,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        conv_busy
);

    localparam logic [7:0] c_LAST = 8'(DIGIT_CYC - 1);

    state_t          r_state;
    logic            r_started;
    logic [1:0]      r_pos;
    logic [7:0]      r_cyc;
    logic [4:0]      r_cap_hr;
    logic [5:0]      r_cap_min;
    logic [5:0]      r_cap_sec;
    logic            r_cap_mode;
    logic [3:0][3:0] r_shd_dig;
    logic            r_shd_mode;
    logic [3:0][3:0] r_dsp_dig;
    logic            r_dsp_mode;
    logic            r_conv_busy;

    logic            w_frame_start;
    logic            w_start;
    logic [5:0]      w_fld_a;
    logic [5:0]      w_fld_b;
    logic            w_done_a;
    logic            w_done_b;
    logic [2:0]      w_tens_a;
    logic [2:0]      w_tens_b;
    logic [3:0]      w_units_a;
    logic [3:0]      w_units_b;
    logic [3:0]      w_digit;

    assign w_frame_start = !r_started || ((r_pos == 2'd0) && (r_cyc == c_LAST));
    assign w_start       = (r_state == S_CAPTURE);
    assign w_fld_a       = r_cap_mode ? r_cap_min : {1'b0, r_cap_hr};
    assign w_fld_b       = r_cap_mode ? r_cap_sec : r_cap_min;

    bin2bcd_seq u_conv_a (
        .clk     (kh_clk),
        .rst_n   (reset),
        .i_start (w_start),
        .i_bin   (w_fld_a),
        .o_done  (w_done_a),
        .o_tens  (w_tens_a),
        .o_units (w_units_a)
    );

    bin2bcd_seq u_conv_b (
        .clk     (kh_clk),
        .rst_n   (reset),
        .i_start (w_start),
        .i_bin   (w_fld_b),
        .o_done  (w_done_b),
        .o_tens  (w_tens_b),
        .o_units (w_units_b)
    );

`ifdef BLINK_COLON_EN
    logic [9:0] r_cap_ms;

    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset)
            r_cap_ms <= 10'd0;
        else if (w_frame_start)
            r_cap_ms <= disp_time[c_MS_MSB:c_MS_LSB];
    end

    assign dp = ~(r_started && (r_pos == 2'd2) && (r_cap_ms < 10'd500));
`else
    logic w_unused_ms;
    assign w_unused_ms = ^disp_time[c_MS_MSB:c_MS_LSB];
    assign dp          = 1'b1;
`endif

    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_started   <= 1'b0;
            r_pos       <= 2'd3;
            r_cyc       <= 8'd0;
            r_cap_hr    <= 5'd0;
            r_cap_min   <= 6'd0;
            r_cap_sec   <= 6'd0;
            r_cap_mode  <= 1'b0;
            r_shd_dig   <= '0;
            r_shd_mode  <= 1'b0;
            r_dsp_dig   <= '0;
            r_dsp_mode  <= 1'b0;
            r_conv_busy <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_started  <= 1'b1;
                r_pos      <= 2'd3;
                r_cyc      <= 8'd0;
                r_cap_hr   <= disp_time[c_HR_MSB:c_HR_LSB];
                r_cap_min  <= disp_time[c_MIN_MSB:c_MIN_LSB];
                r_cap_sec  <= disp_time[c_SEC_MSB:c_SEC_LSB];
                r_cap_mode <= show_sec;
                r_dsp_dig  <= r_shd_dig;
                r_dsp_mode <= r_shd_mode;
            end else if (r_cyc == c_LAST) begin
                r_cyc <= 8'd0;
                r_pos <= r_pos - 2'd1;
            end else begin
                r_cyc <= r_cyc + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_frame_start) begin
                        r_state     <= S_CAPTURE;
                        r_conv_busy <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_CONVERT;
                end
                S_CONVERT: begin
                    if (w_done_a && w_done_b) begin
                        r_state     <= S_DONE;
                        r_conv_busy <= 1'b0;
                        r_shd_dig   <= {{1'b0, w_tens_a}, w_units_a,
                                        {1'b0, w_tens_b}, w_units_b};
                        r_shd_mode  <= r_cap_mode;
                    end
                end
                default: begin
                    // With the shortest frame a new frame can start right here
                    if (w_frame_start) begin
                        r_state     <= S_CAPTURE;
                        r_conv_busy <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign conv_busy = r_conv_busy;
    assign w_digit   = r_dsp_dig[r_pos];

    always_comb begin
        an  = 4'b1111;
        seg = c_SEG_BLANK;
        if (r_started) begin
            an = ~(4'b0001 << r_pos);
            if ((r_pos == 2'd3) && !r_dsp_mode && (w_digit == 4'd0))
                seg = c_SEG_BLANK;
            else
                seg = seg_decode(w_digit);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_time_disp_driver.sv
// ============================================================================
// tb_time_disp_driver : directed self-checking bench for time_disp_driver
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_time_disp_driver;

    localparam int DC = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

`ifdef BLINK_COLON_EN
    localparam int EXP_DP2_LO = DC;
`else
    localparam int EXP_DP2_LO = 0;
`endif

    logic        kh_clk    = 1'b0;
    logic        reset     = 1'b0;
    logic [26:0] disp_time = 27'd0;
    logic        show_sec  = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        conv_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] f3, f2, f1, f0;
    int         f_glitch, f_busy, f_dp2, f_dpo;
    bit         f_tmo;

    time_disp_driver #(.DIGIT_CYC(DC)) dut (
        .kh_clk    (kh_clk),
        .reset     (reset),
        .disp_time (disp_time),
        .show_sec  (show_sec),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .conv_busy (conv_busy)
    );

    always #5 kh_clk = ~kh_clk;

    function automatic logic [26:0] pack(input int hr, input int mn, input int sc, input int ms);
        return {5'(hr), 6'(mn), 6'(sc), 10'(ms)};
    endfunction

    // Records one whole frame starting at the next digit-3 entry.
    task automatic capture_frame;
        logic [3:0] prev;
        logic [6:0] sv [4];
        bit         seen [4];
        int         idx;
        prev  = an;
        f_tmo = 1'b1;
        for (int n = 0; n < 64 && f_tmo; n++) begin
            @(negedge kh_clk);
            if (an == 4'b0111 && prev != 4'b0111) f_tmo = 1'b0;
            else prev = an;
        end
        f_glitch = 0; f_busy = 0; f_dp2 = 0; f_dpo = 0;
        for (int k = 0; k < 4; k++) begin
            sv[k]   = 'x;
            seen[k] = 1'b0;
        end
        if (!f_tmo) begin
            for (int c = 0; c < 4 * DC; c++) begin
                if (c > 0) @(negedge kh_clk);
                case (an)
                    4'b0111: idx = 3;
                    4'b1011: idx = 2;
                    4'b1101: idx = 1;
                    4'b1110: idx = 0;
                    default: idx = -1;
                endcase
                if (idx != 3 - c / DC) f_glitch++;
                if (idx >= 0) begin
                    if (!seen[idx]) begin
                        sv[idx]   = seg;
                        seen[idx] = 1'b1;
                    end else if (seg !== sv[idx]) begin
                        f_glitch++;
                    end
                end
                if (dp === 1'b0) begin
                    if (idx == 2) f_dp2++;
                    else          f_dpo++;
                end
                if (conv_busy === 1'b1) f_busy++;
            end
        end
        f3 = sv[3]; f2 = sv[2]; f1 = sv[1]; f0 = sv[0];
    endtask

    task automatic test_reset;
        #1;
        n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL rst_an: got %b want 1111", an); end
        n_tests++; if (seg !== SB) begin n_fail++; $display("FAIL rst_seg: got %b want %b", seg, SB); end
        n_tests++; if (dp !== 1'b1) begin n_fail++; $display("FAIL rst_dp: got %b want 1", dp); end
        n_tests++; if (conv_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", conv_busy); end
        @(negedge kh_clk); @(negedge kh_clk);
        reset = 1'b1;
        capture_frame();
        n_tests++; if (f_tmo) begin n_fail++; $display("FAIL first_frame_timeout: got none want frame"); end
        n_tests++; if ({f3, f2, f1, f0} !== {SB, S0, S0, S0}) begin n_fail++;
            $display("FAIL first_frame_digits: got %b %b %b %b want %b %b %b %b", f3, f2, f1, f0, SB, S0, S0, S0); end
        n_tests++; if (f_glitch !== 0) begin n_fail++; $display("FAIL first_frame_scan: got %0d glitches want 0", f_glitch); end
        n_tests++; if (f_busy !== 2) begin n_fail++; $display("FAIL first_frame_busy: got %0d want 2", f_busy); end
    endtask

    task automatic test_hhmm;
        disp_time = pack(13, 45, 0, 0);
        show_sec  = 1'b0;
        capture_frame();
        capture_frame();
        n_tests++; if (f_tmo) begin n_fail++; $display("FAIL hhmm_timeout: got none want frame"); end
        n_tests++; if ({f3, f2, f1, f0} !== {S1, S3, S4, S5}) begin n_fail++;
            $display("FAIL hhmm_digits: got %b %b %b %b want %b %b %b %b", f3, f2, f1, f0, S1, S3, S4, S5); end
        n_tests++; if (f_glitch !== 0) begin n_fail++; $display("FAIL hhmm_scan: got %0d glitches want 0", f_glitch); end
        n_tests++; if (f_busy !== 5) begin n_fail++; $display("FAIL hhmm_busy: got %0d want 5", f_busy); end
    endtask

    task automatic test_blank;
        disp_time = pack(7, 5, 0, 0);
        show_sec  = 1'b0;
        capture_frame();
        capture_frame();
        n_tests++; if ({f3, f2, f1, f0} !== {SB, S7, S0, S5}) begin n_fail++;
            $display("FAIL blank_digits: got %b %b %b %b want %b %b %b %b", f3, f2, f1, f0, SB, S7, S0, S5); end
        n_tests++; if (f_busy !== 2) begin n_fail++; $display("FAIL blank_busy: got %0d want 2", f_busy); end
    endtask

    task automatic test_mmss_change;
        logic [27:0] fr;
        logic [27:0] old_v;
        logic [27:0] new_v;
        old_v     = {S5, S9, S5, S9};
        new_v     = {S0, S0, S0, S0};
        disp_time = pack(0, 59, 59, 0);
        show_sec  = 1'b1;
        capture_frame();
        capture_frame();
        fr = {f3, f2, f1, f0};
        n_tests++; if (fr !== old_v) begin n_fail++; $display("FAIL mmss_5959: got %h want %h", fr, old_v); end
        n_tests++; if (f_busy !== 6) begin n_fail++; $display("FAIL mmss_busy: got %0d want 6", f_busy); end
        repeat ($urandom_range(0, 4 * DC - 1)) @(negedge kh_clk);
        disp_time = pack(0, 0, 0, 0);
        capture_frame();
        fr = {f3, f2, f1, f0};
        n_tests++; if ((fr !== old_v && fr !== new_v) || f_glitch != 0) begin n_fail++;
            $display("FAIL mmss_mix1: got %h glitches %0d want %h or %h", fr, f_glitch, old_v, new_v); end
        capture_frame();
        fr = {f3, f2, f1, f0};
        n_tests++; if (fr !== new_v || f_glitch != 0) begin n_fail++;
            $display("FAIL mmss_latency: got %h glitches %0d want %h", fr, f_glitch, new_v); end
    endtask

    task automatic test_max63;
        disp_time = pack(0, 63, 63, 0);
        show_sec  = 1'b1;
        capture_frame();
        capture_frame();
        n_tests++; if ({f3, f2, f1, f0} !== {S6, S3, S6, S3}) begin n_fail++;
            $display("FAIL max63_digits: got %b %b %b %b want %b %b %b %b", f3, f2, f1, f0, S6, S3, S6, S3); end
        n_tests++; if (f_busy !== 7) begin n_fail++; $display("FAIL max63_busy: got %0d want 7", f_busy); end
    endtask

    task automatic test_reset_mid_convert;
        @(negedge kh_clk); @(negedge kh_clk); @(negedge kh_clk);
        n_tests++; if (conv_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b want 1", conv_busy); end
        reset = 1'b0;
        #1;
        n_tests++; if ({an, seg, dp, conv_busy} !== {4'b1111, SB, 1'b1, 1'b0}) begin n_fail++;
            $display("FAIL midrst_outputs: got an %b seg %b dp %b busy %b want 1111 %b 1 0", an, seg, dp, conv_busy, SB); end
        disp_time = pack(7, 5, 0, 0);
        show_sec  = 1'b0;
        @(negedge kh_clk); @(negedge kh_clk);
        reset = 1'b1;
        capture_frame();
        n_tests++; if ({f3, f2, f1, f0} !== {SB, S0, S0, S0}) begin n_fail++;
            $display("FAIL midrst_no_commit: got %b %b %b %b want %b %b %b %b", f3, f2, f1, f0, SB, S0, S0, S0); end
        capture_frame();
        n_tests++; if ({f3, f2, f1, f0} !== {SB, S7, S0, S5}) begin n_fail++;
            $display("FAIL midrst_post: got %b %b %b %b want %b %b %b %b", f3, f2, f1, f0, SB, S7, S0, S5); end
    endtask

    task automatic test_colon;
        disp_time = pack(13, 45, 0, 250);
        show_sec  = 1'b0;
        capture_frame();
        capture_frame();
        n_tests++; if (f_dp2 !== EXP_DP2_LO) begin n_fail++; $display("FAIL colon250_d2: got %0d low want %0d", f_dp2, EXP_DP2_LO); end
        n_tests++; if (f_dpo !== 0) begin n_fail++; $display("FAIL colon250_other: got %0d low want 0", f_dpo); end
        disp_time = pack(13, 45, 0, 750);
        capture_frame();
        capture_frame();
        n_tests++; if ((f_dp2 + f_dpo) !== 0) begin n_fail++; $display("FAIL colon750: got %0d low want 0", f_dp2 + f_dpo); end
    endtask

    initial begin
        test_reset();
        test_hhmm();
        test_blank();
        test_mmss_change();
        test_max63();
        test_reset_mid_convert();
        test_colon();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/time_disp_driver.md
TIME_DISP_DRIVER -- requirements
Module: time_disp_driver

Interface
REQ-001 SHALL have parameter DIGIT_CYC, default 4: kh_clk cycles each digit stays enabled (legal 2..255).
REQ-002 SHALL have port kh_clk  in  1  1 kHz system clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port disp_time  in  27  packed time {hr[26:22], min[21:16], sec[15:10], ms[9:0]} from the 24-hour clock stage.
REQ-005 SHALL have port show_sec  in  1  mode select: 0 = HH:MM, 1 = MM:SS.
REQ-006 SHALL have port an  out  4  active-low digit enables; an[3] = leftmost digit.
REQ-007 SHALL have port seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-008 SHALL have port dp  out  1  active-low decimal point/colon.
REQ-009 SHALL have port conv_busy  out  1  high while a conversion is in progress.

Function
REQ-010 SHALL run a frame of 4*DIGIT_CYC cycles, scanning digits 3,2,1,0 in order, DIGIT_CYC cycles each; exactly one an bit low at any time after reset.
REQ-011 SHALL, on the first cycle of each frame, snapshot disp_time and show_sec into a capture register.
REQ-012 SHALL select fields hr/min when the captured show_sec is 0, and min/sec when it is 1.
REQ-013 SHALL use FSM states IDLE -> CAPTURE -> CONVERT -> DONE -> IDLE.
REQ-014 IDLE SHALL exit on frame start; CAPTURE SHALL last 1 cycle; CONVERT SHALL last until both converters report done; DONE SHALL last 1 cycle.
REQ-015 SHALL convert both fields in parallel by repeated subtract-10, one subtraction per cycle, 0-6 iterations each; a 6-bit input of 0..63 SHALL yield correct tens/units (e.g. 63 -> 6,3).
REQ-016 conv_busy SHALL be high in CAPTURE and CONVERT and low otherwise; worst-case busy is 7 cycles, which is always less than one frame.
REQ-017 SHALL write converted digits to a shadow register in DONE, and SHALL copy them to the display register only at the next frame start, so no frame ever shows mixed old/new digits.
REQ-018 Display latency from a disp_time change SHALL be at most two frames.
REQ-019 SHALL drive seg from the display digit selected by the scan: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 In HH:MM mode, SHALL blank the hour-tens digit (seg = 1111111 with its an still low) when that digit is 0; MM:SS mode SHALL NOT blank any digit.
REQ-021 An input change mid-conversion SHALL NOT affect that conversion; it is taken at the next snapshot.

Reset
REQ-022 Asserting reset SHALL immediately force an=1111, seg=1111111, dp=1, conv_busy=0, FSM=IDLE, scan position=digit 3, cycle counter=0, and shadow/display digits=0.
REQ-023 The first frame SHALL start on the first kh_clk edge after reset deasserts; the display SHALL show blank/zero until the first commit.
REQ-024 Reset asserted mid-conversion SHALL abandon the conversion with no partial commit.

Configuration
REQ-025 With BLINK_COLON_EN defined, dp SHALL be low on digit 2 when the captured ms < 500 and high otherwise, giving a 1 Hz colon blink; dp SHALL be high on all other digits.
REQ-026 Without BLINK_COLON_EN, dp SHALL be constant 1 and no ms logic SHALL be synthesized.

Structure
REQ-027 Package clock_disp_pkg SHALL hold the FSM state enum, the ten seven-segment constants, the blank pattern, and the disp_time field bit positions.
REQ-028 A sub-module bin2bcd_seq (6-bit input, start/done handshake, tens/units outputs) SHALL be instantiated twice.

Verification
REQ-029 hr=13, min=45, show_sec=0, after two frames -> digits 3..0 show 1,3,4,5: seg 1111001, 0110000, 0011001, 0010010.
REQ-030 hr=7, min=5, show_sec=0 -> digit 3 blank (1111111), then 7, 0, 5.
REQ-031 min=59, sec=59, show_sec=1; change to 00:00 at a random cycle -> each frame shows 5959 or 0000 only, never a mix; 0000 appears within two frames.
REQ-032 Field value 63 forced -> 6,3 displayed; conv_busy high for exactly 7 cycles.
REQ-033 Reset pulsed during CONVERT -> outputs reach their REQ-022 values immediately; the next commit reflects only the post-reset snapshot.
REQ-034 BLINK_COLON_EN defined, ms=250 -> dp=0 on digit 2 only; ms=750 -> dp=1 on all digits; undefined -> dp=1 always.
